// File: rtl/adder_bist.sv
// Built-in self test for an external 8-bit adder: drives LFSR-derived operands,
// compares the returned sum/carry against a registered 9-bit reference and logs failures.
module adder_bist #(
  parameter int unsigned NUM_VECTORS = 256,
  parameter int unsigned SETTLE      = 1,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  output logic [7:0]  x_o,
  output logic [7:0]  y_o,
  output logic        carry_in_o,
  input  logic [7:0]  sum_i,
  input  logic        carry_output_bit_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [15:0] err_count_o,
  output logic [15:0] first_fail_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [15:0] LAST_IDX  = 16'(NUM_VECTORS - 1);
  localparam logic [3:0]  WAIT_LAST = 4'(SETTLE - 1);
  localparam logic [15:0] NO_FAIL   = 16'hFFFF;

  logic [2:0]  state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] idx_q, idx_d;
  logic [3:0]  wait_q, wait_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic        cin_q, cin_d;
  logic [8:0]  exp_q, exp_d;
  logic [15:0] err_q, err_d;
  logic [15:0] ff_q, ff_d;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    x_d     = x_q;
    y_d     = y_q;
    cin_d   = cin_q;
    exp_d   = exp_q;
    err_d   = err_q;
    ff_d    = ff_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_LAUNCH;
          lfsr_d  = SEED;
          idx_d   = '0;
          err_d   = '0;
          ff_d    = NO_FAIL;
        end
      end
      S_LAUNCH: begin
        x_d    = lfsr_q[7:0];
        y_d    = lfsr_q[15:8];
        cin_d  = idx_q[0];
        // Reference computed from the LFSR directly so it is ready with the operands.
        exp_d  = {1'b0, lfsr_q[7:0]} + {1'b0, lfsr_q[15:8]} + {8'd0, idx_q[0]};
        wait_d = '0;
        state_d = (SETTLE == 0) ? S_CHECK : S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = S_CHECK;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      S_CHECK: begin
        if ({carry_output_bit_i, sum_i} != exp_q) begin
          if (err_q != '1) begin
            err_d = err_q + 16'd1;
          end
          if (ff_q == NO_FAIL) begin
            ff_d = idx_q;
          end
        end
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 16'd1;
          state_d = S_LAUNCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      idx_q   <= '0;
      wait_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cin_q   <= 1'b0;
      exp_q   <= '0;
      err_q   <= '0;
      ff_q    <= NO_FAIL;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cin_q   <= cin_d;
      exp_q   <= exp_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
    end
  end

  assign x_o          = x_q;
  assign y_o          = y_q;
  assign carry_in_o   = cin_q;
  assign busy_o       = (state_q == S_LAUNCH) || (state_q == S_WAIT) || (state_q == S_CHECK);
  assign done_o       = (state_q == S_DONE);
  assign pass_o       = done_o && (err_q == '0);
  assign err_count_o  = err_q;
  assign first_fail_o = ff_q;

endmodule

// File: tb/tb_adder_bist.sv
// Randomised scoreboard bench for adder_bist: a driver issues runs against a
// faultable adder model, a monitor checks every vector and every run result.
module tb_adder_bist;

  localparam int unsigned NV   = 256;
  localparam int unsigned ST   = 1;
  localparam int unsigned P    = 2 + ST;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start;
  logic [7:0]  x, y, sum;
  logic        cin, cout, busy, done, pass;
  logic [15:0] errc, ffail;
  logic [8:0]  s9;
  int          fault_mode;

  logic        start2;
  logic [7:0]  x2, y2, sum2;
  logic        cin2, cout2, busy2, done2, pass2;
  logic [15:0] errc2, ffail2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Adder under test with selectable faults: 1 = sum bit 0 stuck at 0, 2 = carry-out tied 0.
  always_comb begin
    s9   = {1'b0, x} + {1'b0, y} + {8'd0, cin};
    sum  = s9[7:0];
    cout = s9[8];
    if (fault_mode == 1) sum[0] = 1'b0;
    if (fault_mode == 2) cout = 1'b0;
  end

  assign {cout2, sum2} = {1'b0, x2} + {1'b0, y2} + {8'd0, cin2};

  adder_bist #(.NUM_VECTORS(NV), .SETTLE(ST), .SEED(SEED)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .x_o(x), .y_o(y), .carry_in_o(cin),
    .sum_i(sum), .carry_output_bit_i(cout),
    .busy_o(busy), .done_o(done), .pass_o(pass),
    .err_count_o(errc), .first_fail_o(ffail)
  );

  adder_bist #(.NUM_VECTORS(1), .SETTLE(0), .SEED(SEED)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start2),
    .x_o(x2), .y_o(y2), .carry_in_o(cin2),
    .sum_i(sum2), .carry_output_bit_i(cout2),
    .busy_o(busy2), .done_o(done2), .pass_o(pass2),
    .err_count_o(errc2), .first_fail_o(ffail2)
  );

  typedef struct { logic [7:0] x; logic [7:0] y; logic c; } vec_t;
  typedef struct { int err; int ff; int pass; } run_t;
  vec_t vec_q[$];
  run_t run_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk the LFSR sequence, add with integers, apply the fault to the true sum.
  task automatic expect_run(input int fault);
    logic [15:0] l;
    int err, ff, tru, got;
    vec_t v;
    run_t r;
    l = SEED; err = 0; ff = 'hFFFF;
    for (int k = 0; k < int'(NV); k++) begin
      v.x = l[7:0];
      v.y = l[15:8];
      v.c = k[0];
      tru = int'(v.x) + int'(v.y) + int'(v.c);
      got = tru;
      if (fault == 1) got = tru & ~1;
      if (fault == 2) got = tru & 'hFF;
      if (got != tru) begin
        if (err < 'hFFFF) err++;
        if (ff == 'hFFFF) ff = k;
      end
      vec_q.push_back(v);
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
    r.err = err; r.ff = ff; r.pass = (err == 0) ? 1 : 0;
    run_q.push_back(r);
  endtask

  task automatic pulse_start();
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < int'(NV * P) + 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done_seen"}, done, 1);
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(0, 5)) @(negedge clk);
  endtask

  // Monitor: per-vector operand check in CHECK, per-run result check on done rise.
  initial begin
    logic bprev, dprev;
    int cnt, launch_cyc;
    vec_t v;
    run_t r;
    bprev = 1'b0; dprev = 1'b0; cnt = 0; launch_cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bprev = 1'b0;
        dprev = 1'b0;
      end else begin
        if (busy && !bprev) begin
          cnt = 0;
          launch_cyc = cyc;
        end else if (busy) begin
          cnt++;
        end
        if (busy && (cnt % int'(P) == int'(P) - 1)) begin
          chk("vec_expected", vec_q.size() > 0, 1);
          if (vec_q.size() > 0) begin
            v = vec_q.pop_front();
            chk("x_o", x, v.x);
            chk("y_o", y, v.y);
            chk("carry_in_o", cin, v.c);
          end
        end
        if (done && !dprev) begin
          chk("run_expected", run_q.size() > 0, 1);
          if (run_q.size() > 0) begin
            r = run_q.pop_front();
            chk("err_count_o", errc, r.err);
            chk("first_fail_o", ffail, r.ff);
            chk("pass_o", pass, r.pass);
            chk("run_cycles", cyc - launch_cyc, NV * P);
          end
        end
        bprev = busy;
        dprev = done;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, elapsed, gap;
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; fault_mode = 0;
    #23;
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_cin", cin, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", errc, 0);
    chk("rst_ff", ffail, 16'hFFFF);
    chk("rst_ff2", ffail2, 16'hFFFF);
    @(negedge clk); #1 rst_n = 1'b1;

    // Golden run with a correct adder
    idle_gap();
    expect_run(0);
    pulse_start();
    @(negedge clk);
    chk("first_x", x, 8'hE1);
    chk("first_y", y, 8'hAC);
    chk("first_cin", cin, 0);
    wait_done("golden");
    chk("golden_pass", pass, 1);
    chk("golden_err", errc, 0);
    chk("golden_ff", ffail, 16'hFFFF);
    chk("golden_busy", busy, 0);

    // Sum bit 0 stuck at 0
    idle_gap();
    fault_mode = 1;
    expect_run(1);
    pulse_start();
    wait_done("stuck_sum0");
    chk("stuck_sum0_pass", pass, 0);

    // Carry-out tied 0: vector 0 already needs a carry
    idle_gap();
    fault_mode = 2;
    expect_run(2);
    pulse_start();
    wait_done("no_carry");
    chk("no_carry_ff", ffail, 0);
    chk("no_carry_pass", pass, 0);

    // Spurious start pulses during a run
    idle_gap();
    fault_mode = 0;
    expect_run(0);
    pulse_start();
    elapsed = 0;
    while (elapsed < int'(NV * P) - 80) begin
      gap = $urandom_range(1, 40);
      repeat (gap) @(negedge clk);
      #1 start = 1'b1;
      @(negedge clk); #1 start = 1'b0;
      elapsed += gap + 1;
    end
    wait_done("disturbed");

    // Start held in DONE restarts immediately
    expect_run(0);
    #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    chk("restart_busy", busy, 1);
    chk("restart_err_cleared", errc, 0);
    wait_done("held_start");

    // Asynchronous reset in the middle of a WAIT cycle
    idle_gap();
    fault_mode = 1;
    expect_run(1);
    pulse_start();
    k = $urandom_range(5, 100);
    repeat (3 * k + 1) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_x", x, 0);
    chk("abort_y", y, 0);
    chk("abort_cin", cin, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_pass", pass, 0);
    chk("abort_err", errc, 0);
    chk("abort_ff", ffail, 16'hFFFF);
    vec_q.delete();
    run_q.delete();
    fault_mode = 0;
    @(negedge clk); #1 rst_n = 1'b1;
    expect_run(0);
    pulse_start();
    wait_done("after_reset");
    chk("after_reset_pass", pass, 1);
    chk("after_reset_ff", ffail, 16'hFFFF);

    // Single vector, no settle cycles
    @(negedge clk); #1 start2 = 1'b1;
    @(negedge clk); #1 start2 = 1'b0;
    chk("s0_launch_busy", busy2, 1);
    chk("s0_launch_done", done2, 0);
    @(negedge clk);
    chk("s0_check_done", done2, 0);
    chk("s0_check_x", x2, 8'hE1);
    @(negedge clk);
    chk("s0_done", done2, 1);
    chk("s0_pass", pass2, 1);
    #1 start2 = 1'b1;
    @(negedge clk); #1 start2 = 1'b0;
    chk("s0_again_busy", busy2, 1);
    @(negedge clk);
    chk("s0_again_x", x2, 8'hE1);
    chk("s0_again_y", y2, 8'hAC);
    chk("s0_again_cin", cin2, 0);
    @(negedge clk);
    chk("s0_again_done", done2, 1);
    chk("s0_again_err", errc2, 0);

    repeat (3) @(negedge clk);
    chk("vec_q_drained", vec_q.size(), 0);
    chk("run_q_drained", run_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
